// File: rtl/led_pkg.sv
// Shared encodings, widths and helpers for the LED sequence controller.
`default_nettype none

package led_pkg;

  localparam int unsigned c_PHASE_W = 16;
  localparam int unsigned c_CYCLE_W = 8;

  typedef logic [c_PHASE_W-1:0] phase_t;
  typedef logic [c_CYCLE_W-1:0] cycle_t;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STEADY = 2'd1,
    ST_ON_PH  = 2'd2,
    ST_OFF_PH = 2'd3
  } state_t;

  // A zero-length phase still lasts one tick.
  function automatic phase_t eff_len(input phase_t v);
    return (v == '0) ? phase_t'(1) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_seq_ctrl_if.sv
// Command channel of the LED sequence controller (valid/ready handshake).
`default_nettype none

interface led_seq_ctrl_if;
  import led_pkg::*;

  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_mode;
  phase_t     cfg_on;
  phase_t     cfg_off;
  cycle_t     cfg_count;

  modport master (
    output cfg_valid, cfg_mode, cfg_on, cfg_off, cfg_count,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_mode, cfg_on, cfg_off, cfg_count,
    output cfg_ready
  );

endinterface

`default_nettype wire

// File: rtl/led_tick_gen.sv
// Timebase prescaler: one-cycle tick every CLK_HZ/TICK_HZ cycles after clr.
`default_nettype none

module led_tick_gen #(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned TICK_HZ = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  // CLK_HZ/TICK_HZ must be at least 2.
  localparam int unsigned      c_DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned      c_CNT_W = $clog2(c_DIV);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_DIV - 1);

  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (clr || (r_cnt == c_LAST))
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + c_CNT_W'(1);
  end

  assign tick = (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/led_seq_ctrl.sv
// LED sequence controller: OFF / steady ON / counted or endless blink.
`default_nettype none

module led_seq_ctrl
  import led_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned TICK_HZ = 1000
) (
  input  logic          clk,
  input  logic          rst,
  led_seq_ctrl_if.slave cfg,
  output logic          led_out,
  output logic          busy,
  output logic          done
);

  state_t r_state, w_state_nxt;
  logic   r_led, w_led_nxt;
  logic   r_done, w_done_nxt;
  phase_t r_phase, w_phase_nxt;
  cycle_t r_cycle, w_cycle_nxt;
  phase_t r_on, r_off;
  cycle_t r_count;
  logic   w_accept;
  logic   w_tick;
  logic   w_busy;

  led_tick_gen #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (w_accept),
    .tick(w_tick)
  );

  // Only a counted blink blocks new commands; endless blink stays preemptible.
  assign w_busy        = ((r_state == ST_ON_PH) || (r_state == ST_OFF_PH)) && (r_count != '0);
  assign cfg.cfg_ready = ~w_busy;
  assign w_accept      = cfg.cfg_valid & ~w_busy;

  always_comb begin
    w_state_nxt = r_state;
    w_led_nxt   = r_led;
    w_done_nxt  = 1'b0;
    w_phase_nxt = r_phase;
    w_cycle_nxt = r_cycle;
    if (w_accept) begin
      w_phase_nxt = '0;
      w_cycle_nxt = '0;
      case (cfg.cfg_mode)
        MODE_ON: begin
          w_state_nxt = ST_STEADY;
          w_led_nxt   = 1'b1;
        end
        MODE_BLINK: begin
          w_state_nxt = ST_ON_PH;
          w_led_nxt   = 1'b1;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_led_nxt   = 1'b0;
        end
      endcase
    end else begin
      case (r_state)
        ST_ON_PH: begin
          if (w_tick) begin
            if (r_phase == eff_len(r_on) - phase_t'(1)) begin
              w_state_nxt = ST_OFF_PH;
              w_led_nxt   = 1'b0;
              w_phase_nxt = '0;
            end else begin
              w_phase_nxt = r_phase + phase_t'(1);
            end
          end
        end
        ST_OFF_PH: begin
          if (w_tick) begin
            if (r_phase == eff_len(r_off) - phase_t'(1)) begin
              w_phase_nxt = '0;
              if ((r_count != '0) && (r_cycle == r_count - cycle_t'(1))) begin
                w_state_nxt = ST_IDLE;
                w_led_nxt   = 1'b0;
                w_done_nxt  = 1'b1;
              end else begin
                w_state_nxt = ST_ON_PH;
                w_led_nxt   = 1'b1;
                if (r_count != '0)
                  w_cycle_nxt = r_cycle + cycle_t'(1);
              end
            end else begin
              w_phase_nxt = r_phase + phase_t'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_led   <= 1'b0;
      r_done  <= 1'b0;
      r_phase <= '0;
      r_cycle <= '0;
      r_on    <= '0;
      r_off   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_led   <= w_led_nxt;
      r_done  <= w_done_nxt;
      r_phase <= w_phase_nxt;
      r_cycle <= w_cycle_nxt;
      if (w_accept) begin
        r_on    <= cfg.cfg_on;
        r_off   <= cfg.cfg_off;
        r_count <= cfg.cfg_count;
      end
    end
  end

  assign led_out = r_led;
  assign busy    = w_busy;
  assign done    = r_done;

endmodule

`default_nettype wire

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 50000000, is the input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1000, is the timebase tick rate in Hz; DIV = CLK_HZ/TICK_HZ and must be at least 2.
REQ-003 Port clk, input, 1 bit, is the single clock; all logic is rising-edge.
REQ-004 Port rst, input, 1 bit, is an asynchronous, active-high reset.
REQ-005 Port cfg_valid, input, 1 bit, means a command is presented.
REQ-006 Port cfg_ready, output, 1 bit, means a command can be accepted; a command is accepted when cfg_valid and cfg_ready are both 1 at a clk edge.
REQ-007 Port cfg_mode, input, 2 bits: 0 = OFF, 1 = ON, 2 = BLINK, 3 = reserved (treated as OFF).
REQ-008 Port cfg_on, input, 16 bits, is the ON phase length in ticks.
REQ-009 Port cfg_off, input, 16 bits, is the OFF phase length in ticks.
REQ-010 Port cfg_count, input, 8 bits, is the number of blink cycles; 0 means repeat forever.
REQ-011 Port led_out, output, 1 bit, is the registered LED drive and feeds the led module input.
REQ-012 Port busy, output, 1 bit, is 1 while a counted blink sequence is running.
REQ-013 Port done, output, 1 bit, is a 1-cycle pulse when a counted sequence completes.

Function
REQ-014 The FSM shall have four states: IDLE, STEADY, ON_PH and OFF_PH.
REQ-015 cfg_ready shall be 1 in IDLE, in STEADY, and in ON_PH/OFF_PH when the loaded count is 0; it shall be 0 during a counted blink.
REQ-016 On acceptance, command fields shall be registered, the tick prescaler cleared, and the phase counter cleared in the same edge.
REQ-017 On acceptance, led_out shall take its new value on the accepting edge (zero-cycle latency as seen on the next cycle).
REQ-018 Accepting OFF or mode 3 shall go to IDLE with led_out=0.
REQ-019 Accepting ON shall go to STEADY with led_out=1.
REQ-020 Accepting BLINK shall go to ON_PH with led_out=1.
REQ-021 The tick shall be a 1-cycle pulse every DIV clk cycles after the prescaler clears.
REQ-022 The phase counter shall increment on each tick and clear on every phase change.
REQ-023 ON_PH to OFF_PH: when the phase counter reaches max(cfg_on,1) ticks, the block shall set led_out=0.
REQ-024 OFF_PH to ON_PH: when the phase counter reaches max(cfg_off,1) ticks, the block shall set led_out=1 and increment the cycle counter.
REQ-025 A zero cfg_on or cfg_off shall be treated as 1 tick.
REQ-026 When cfg_count≠0, at the end of the OFF phase of cycle cfg_count the block shall go to IDLE with led_out=0 and done=1 for one cycle; busy shall drop on the same edge.
REQ-027 When cfg_count=0, the block shall blink indefinitely, and a new accepted command preempts the blink immediately.
REQ-028 A command arriving while cfg_ready=0 shall be ignored, with no state change.
REQ-029 The cycle counter shall be 8 bits and never wrap in counted mode; forever mode shall not advance it.

Reset
REQ-030 Asserting rst shall immediately force IDLE, with led_out=0, busy=0, done=0, cfg_ready=1, and all counters and registered fields at 0.
REQ-031 Reset mid-sequence shall abort the sequence with no done pulse; operation shall resume on the first edge after rst deasserts.

Structure
REQ-032 The mode encodings, FSM state encodings and the counter widths (16-bit phase, 8-bit cycle) shall be in a shared package/include led_pkg.
REQ-033 The prescaler shall be a sub-module led_tick_gen (parameters CLK_HZ, TICK_HZ; ports clk, rst, clr, tick).

Verification (CLK_HZ=10, TICK_HZ=1, so DIV=10)
REQ-034 Accept BLINK on=2, off=3, count=2 -> led_out high 20 cycles, low 30, high 20, low 30; done pulses once; busy high for 100 cycles; then IDLE.
REQ-035 Accept BLINK count=0, then ON after 47 cycles -> led_out=1 steadily from the accept edge; no done pulse.
REQ-036 During a counted blink, assert cfg_valid with OFF -> cfg_ready=0, the command is ignored, and the sequence completes unchanged.
REQ-037 BLINK on=0, off=0, count=3 -> a 10-cycle high / 10-cycle low pattern repeated 3 times, then done.
REQ-038 Assert rst mid-ON_PH for 1 cycle -> led_out=0 immediately, busy=0, no done pulse, cfg_ready=1.
REQ-039 Send mode 3 while STEADY -> IDLE with led_out=0 on the next cycle.
